// File: rtl/arb_pkg.sv
// Shared types, sizes and the round-robin winner search for rr_arbiter_8.
package arb_pkg;

   localparam int unsigned N_REQ          = 8;
   localparam int unsigned SEL_W          = 3;
   localparam int unsigned TIMEOUT_CYCLES = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // First set bit of req found by scanning ptr, ptr+1, ... with mod-8 wrap.
   function automatic logic [SEL_W-1:0] next_winner(input logic [N_REQ-1:0] req,
                                                    input logic [SEL_W-1:0] ptr);
      logic [SEL_W-1:0] idx;
      logic             found;
      next_winner = ptr;
      found       = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = ptr + SEL_W'(i);
         if (!found && req[idx]) begin
            next_winner = idx;
            found       = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the 8 requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if;
   import arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic             done;
   logic [SEL_W-1:0] sel;
   logic [N_REQ-1:0] gnt;
   logic             gnt_valid;
   logic             timeout;

   modport master (
      output req, done,
      input  sel, gnt, gnt_valid, timeout
   );

   modport slave (
      input  req, done,
      output sel, gnt, gnt_valid, timeout
   );

endinterface

// File: rtl/rr_arbiter_8_dec.sv
// Existing 3-to-8 binary-to-one-hot decoder feeding the grant vector.
module decoder_3_to_8 (
   input  logic [2:0] a,
   output logic [7:0] y
);

   always_comb begin
      y    = '0;
      y[a] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with grant lock until done.
// Optional forced release after TIMEOUT_CYCLES busy cycles: define ARB_TIMEOUT_EN.
module rr_arbiter_8
   import arb_pkg::*;
(
   input logic         clk,
   input logic         rst_n,
   rr_arbiter_8_if.slave bus
);

   arb_state_t       state, state_nxt;
   logic [SEL_W-1:0] ptr, ptr_nxt;
   logic [SEL_W-1:0] sel, sel_nxt;
   logic [N_REQ-1:0] dec_y;
   logic             release_now;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             timeout_q, timeout_nxt;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
         sel   <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt       <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         sel   <= sel_nxt;
`ifdef ARB_TIMEOUT_EN
         cnt       <= cnt_nxt;
         timeout_q <= timeout_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      sel_nxt     = sel;
      release_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_nxt     = cnt;
      timeout_nxt = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (bus.req != '0) begin
               sel_nxt   = next_winner(bus.req, ptr);
               state_nxt = BUSY;
`ifdef ARB_TIMEOUT_EN
               cnt_nxt   = '0;
`endif
            end
         end
         BUSY: begin
            release_now = bus.done;
`ifdef ARB_TIMEOUT_EN
            cnt_nxt = cnt + CNT_W'(1);
            // done takes precedence, so timeout only flags a genuinely forced release
            if (!bus.done && cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               release_now = 1'b1;
               timeout_nxt = 1'b1;
            end
`endif
            if (release_now) begin
               state_nxt = IDLE;
               ptr_nxt   = sel + SEL_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   decoder_3_to_8 u_dec (
      .a (sel),
      .y (dec_y)
   );

   assign bus.sel       = sel;
   assign bus.gnt_valid = (state == BUSY);
   assign bus.gnt       = dec_y & {N_REQ{bus.gnt_valid}};

`ifdef ARB_TIMEOUT_EN
   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8 (both ARB_TIMEOUT_EN builds).
module tb_rr_arbiter_8;
   import arb_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   rr_arbiter_8_if bus ();

   rr_arbiter_8 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_grant(input string tag, input logic [2:0] exp_sel);
      logic [7:0] exp_gnt;
      exp_gnt          = '0;
      exp_gnt[exp_sel] = 1'b1;
      chk({tag, "_valid"}, {7'd0, bus.gnt_valid}, 8'h01);
      chk({tag, "_sel"}, {5'd0, bus.sel}, {5'd0, exp_sel});
      chk({tag, "_gnt"}, bus.gnt, exp_gnt);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, {7'd0, bus.gnt_valid}, 8'h00);
      chk({tag, "_gnt"}, bus.gnt, 8'h00);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.req  = 8'hFF;
      bus.done = 1'b0;

      // reset with all requests asserted
      tick();
      tick();
      chk_idle("rst");
      chk("rst_sel", {5'd0, bus.sel}, 8'h00);
      chk("rst_timeout", {7'd0, bus.timeout}, 8'h00);

      // single request, then release
      rst_n   = 1'b1;
      bus.req = 8'h04;
      tick();
      chk_grant("single", 3'd2);
      bus.req  = 8'h00;
      bus.done = 1'b1;
      tick();
      chk_idle("single_rel");
      bus.done = 1'b0;

      // ptr now 3: req 0 and 3 -> 3 first, then 0
      bus.req = 8'h09;
      tick();
      chk_grant("ptr3_a", 3'd3);
      bus.done = 1'b1;
      tick();
      chk_idle("ptr3_rel");
      bus.done = 1'b0;
      tick();
      chk_grant("ptr3_b", 3'd0);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;

      // done in IDLE is ignored, no request keeps IDLE
      bus.req  = 8'h00;
      bus.done = 1'b1;
      tick();
      chk_idle("idle_done");
      bus.done = 1'b0;

      // full rotation with wrap after reset
      rst_n   = 1'b0;
      bus.req = 8'hFF;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 9; k++) begin
         tick();
         chk_grant("rot", 3'(k % 8));
         bus.done = 1'b1;
         tick();
         chk_idle("rot_rel");
         bus.done = 1'b0;
      end

      // BUSY ignores req changes, reset mid-BUSY
      bus.req = 8'h20;
      tick();
      chk_grant("g5", 3'd5);
      bus.req = 8'h01;
      tick();
      chk_grant("g5_hold", 3'd5);
      rst_n   = 1'b0;
      bus.req = 8'hFF;
      tick();
      chk_idle("midrst");
      chk("midrst_sel", {5'd0, bus.sel}, 8'h00);
      rst_n = 1'b1;
      tick();
      chk_grant("post_rst", 3'd0);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;

      // grant 1 with done held low
      bus.req = 8'h02;
      tick();
      chk_grant("hold", 3'd1);
      bus.req = 8'hFF;
`ifdef ARB_TIMEOUT_EN
      for (int k = 0; k < 15; k++) begin
         tick();
         chk_grant("to_hold", 3'd1);
         chk("to_hold_timeout", {7'd0, bus.timeout}, 8'h00);
      end
      tick();
      chk_idle("to_rel");
      chk("to_pulse", {7'd0, bus.timeout}, 8'h01);
      tick();
      chk("to_pulse_end", {7'd0, bus.timeout}, 8'h00);
      chk_grant("to_next", 3'd2);
      // done coinciding with the last count wins
      for (int k = 0; k < 15; k++) tick();
      chk_grant("to_last", 3'd2);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      chk_idle("done_wins");
      chk("done_wins_timeout", {7'd0, bus.timeout}, 8'h00);
      tick();
      chk_grant("done_wins_next", 3'd3);
`else
      for (int k = 0; k < 110; k++) begin
         tick();
         chk_grant("nto_hold", 3'd1);
         chk("nto_timeout", {7'd0, bus.timeout}, 8'h00);
      end
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      chk_idle("nto_rel");
      tick();
      chk_grant("nto_next", 3'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
